// File: rtl/cnn_ctrl.sv
// rtl/cnn_ctrl.sv - raster-order window issue sequencer with pipeline drain for the CNN kernel array
// Optional cycle counter output o_cycle_cnt when CNN_CTRL_PERF_CNT_EN is defined.
module cnn_ctrl #(
    parameter int CNN_PIPE = 5,
    parameter int CNT_BW   = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_soft_reset,
    input  logic              i_run,
    input  logic [CNT_BW-1:0] i_num_x,
    input  logic [CNT_BW-1:0] i_num_y,
    input  logic              i_fmap_ready,
    output logic              o_idle,
    output logic              o_running,
    output logic              o_valid,
    output logic [CNT_BW-1:0] o_x,
    output logic [CNT_BW-1:0] o_y,
    output logic              o_last,
    output logic              o_done
`ifdef CNN_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]       o_cycle_cnt
`endif
);

    localparam int DW = $clog2(CNN_PIPE + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_BW-1:0] r_x;
    logic [CNT_BW-1:0] r_y;
    logic [CNT_BW-1:0] r_num_x;
    logic [CNT_BW-1:0] r_num_y;
    logic [DW-1:0]     r_drain;
    logic              r_valid;
    logic              r_last;
    logic [CNT_BW-1:0] r_ox;
    logic [CNT_BW-1:0] r_oy;
    logic              w_issue;
    logic              w_wrap_x;
    logic              w_final;
    logic              w_start;

    // Compares use the latched dims only, so live inputs cannot disturb a run.
    assign w_wrap_x = (r_x == r_num_x - CNT_BW'(1));
    assign w_final  = w_wrap_x && (r_y == r_num_y - CNT_BW'(1));
    assign w_start  = (r_state == S_IDLE) && i_run && !i_soft_reset;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_run) begin
                    w_next = (i_num_x != '0 && i_num_y != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (i_fmap_ready) begin
                    w_issue = 1'b1;
                    if (w_final) begin
                        w_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (r_drain == DW'(1)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (i_soft_reset) begin
            w_next  = S_IDLE;
            w_issue = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_num_x <= '0;
            r_num_y <= '0;
            r_drain <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_ox    <= '0;
            r_oy    <= '0;
        end else if (i_soft_reset) begin
            r_x     <= '0;
            r_y     <= '0;
            r_num_x <= '0;
            r_num_y <= '0;
            r_drain <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_ox    <= '0;
            r_oy    <= '0;
        end else begin
            r_valid <= w_issue;
            r_last  <= w_issue && w_final;
            if (w_start) begin
                r_num_x <= i_num_x;
                r_num_y <= i_num_y;
                r_x     <= '0;
                r_y     <= '0;
            end
            if (w_issue) begin
                r_ox <= r_x;
                r_oy <= r_y;
                if (w_wrap_x) begin
                    r_x <= '0;
                    r_y <= r_y + CNT_BW'(1);
                end else begin
                    r_x <= r_x + CNT_BW'(1);
                end
            end
            if (w_issue && w_final) begin
                r_drain <= DW'(CNN_PIPE);
            end else if (r_state == S_DRAIN) begin
                r_drain <= r_drain - DW'(1);
            end
        end
    end

    assign o_idle    = (r_state == S_IDLE);
    assign o_running = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign o_done    = (r_state == S_DONE);
    assign o_valid   = r_valid;
    assign o_last    = r_last;
    assign o_x       = r_ox;
    assign o_y       = r_oy;

`ifdef CNN_CTRL_PERF_CNT_EN
    logic [31:0] r_cycle_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cycle_cnt <= '0;
        end else if (i_soft_reset) begin
            r_cycle_cnt <= '0;
        end else if (w_start) begin
            r_cycle_cnt <= '0;
        end else if (o_running && r_cycle_cnt != 32'hFFFF_FFFF) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
    end

    assign o_cycle_cnt = r_cycle_cnt;
`endif

endmodule
